// File: rtl/motor_ctrl_pkg.sv
// rtl/motor_ctrl_pkg.sv - shared constants and types for the motor command sequencer
package motor_ctrl_pkg;

    localparam logic [8:0] UPDATE_PHASE = 9'h1fd;

    typedef enum logic [1:0] {
        DRIVE_OFF        = 2'b00,
        DRIVE_SLOW       = 2'b01,
        DRIVE_FAST_BRAKE = 2'b10,
        DRIVE_FAST       = 2'b11
    } drive_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_DWELL     = 3'd3,
        ST_BRAKE     = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    // -512 has no positive counterpart in 10 bits, so it saturates to 511.
    function automatic logic [8:0] duty_magnitude(input logic [9:0] duty);
        logic [9:0] negated;
        negated = (~duty) + 10'd1;
        if (duty == 10'h200) return 9'd511;
        else if (duty[9])    return negated[8:0];
        else                 return duty[8:0];
    endfunction

endpackage

// File: rtl/slew_limiter.sv
// rtl/slew_limiter.sv - moves current toward target by at most step, landing exactly on target
module slew_limiter #(
    parameter int W = 9
) (
    input  logic [W-1:0] current,
    input  logic [W-1:0] target,
    input  logic [W-1:0] step,
    output logic [W-1:0] next
);

    logic [W-1:0] diff;

    always_comb begin
        next = target;
        diff = '0;
        if (target > current) begin
            diff = target - current;
            if (diff > step) next = current + step;
        end else begin
            diff = current - target;
            if (diff > step) next = current - step;
        end
    end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// rtl/motor_cmd_sequencer.sv - PWM-period command sequencer with slew, reverse dwell, brake and stall/fault handling
module motor_cmd_sequencer
    import motor_ctrl_pkg::*;
#(
    parameter int SLEW_STEP       = 8,
    parameter int REVERSE_DWELL   = 4,
    parameter int STALL_PERIODS   = 1024,
    parameter int STALL_MIN_LEVEL = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] pwm_phase,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_duty,
    input  logic       cmd_brake,
    input  logic [2:0] hall,
    input  logic       motor_fault,
    output logic       new_direction,
    output logic [8:0] new_level,
    output logic [1:0] drive_mode,
    input  logic       clear_fault,
    output logic       stall,
    output logic       fault_latched,
    output logic [2:0] state
);

    localparam int CW = $clog2(STALL_PERIODS + 1);
    localparam int DW = (REVERSE_DWELL > 1) ? $clog2(REVERSE_DWELL) : 1;
    localparam logic [CW-1:0] STALL_MAX  = CW'(STALL_PERIODS);
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_PERIODS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(REVERSE_DWELL - 1);
    localparam logic [8:0]    STEP       = 9'(SLEW_STEP);
    localparam logic [8:0]    MIN_LEVEL  = 9'(STALL_MIN_LEVEL);

    seq_state_e  cur_st, nxt_st;
    drive_mode_e mode_q, mode_n;
    logic [8:0]  level_q, level_n;
    logic        dir_q, dir_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [CW-1:0] stall_cnt;
    logic [8:0]  tgt_mag;
    logic        tgt_dir, tgt_brake;
    logic [2:0]  hall_q, hall_prev;
    logic        stall_q, set_stall, reversing;
    logic [8:0]  toward_tgt, toward_zero;

    logic tick, accept, hall_chg, stall_hit, fault_exit;

    assign tick       = (pwm_phase == UPDATE_PHASE);
    assign accept     = cmd_valid && cmd_ready;
    assign hall_chg   = (hall_q != hall_prev);
    assign stall_hit  = tick && !hall_chg && (cur_st != ST_FAULT) &&
                        (level_q >= MIN_LEVEL) && (stall_cnt >= STALL_LAST);
    assign fault_exit = tick && (cur_st == ST_FAULT) && clear_fault && !motor_fault;

    assign cmd_ready     = (cur_st != ST_FAULT);
    assign state         = cur_st;
    assign new_level     = level_q;
    assign new_direction = dir_q;
    assign drive_mode    = mode_q;
    assign stall         = stall_q;
    assign fault_latched = (cur_st == ST_FAULT);

    slew_limiter #(.W(9)) u_slew_tgt (
        .current (level_q),
        .target  (tgt_mag),
        .step    (STEP),
        .next    (toward_tgt)
    );

    slew_limiter #(.W(9)) u_slew_zero (
        .current (level_q),
        .target  (9'd0),
        .step    (STEP),
        .next    (toward_zero)
    );

    // Targets may change on any cycle; the FSM only samples them at the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_mag   <= '0;
            tgt_dir   <= 1'b0;
            tgt_brake <= 1'b0;
        end else if (fault_exit) begin
            tgt_mag   <= '0;
            tgt_dir   <= 1'b0;
            tgt_brake <= 1'b0;
        end else if (accept) begin
            tgt_mag   <= duty_magnitude(cmd_duty);
            tgt_dir   <= cmd_duty[9];
            tgt_brake <= cmd_brake;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_q    <= '0;
            hall_prev <= '0;
            stall_cnt <= '0;
        end else begin
            hall_q    <= hall;
            hall_prev <= hall_q;
            if (hall_chg || fault_exit) begin
                stall_cnt <= '0;
            end else if (tick) begin
                if (level_q < MIN_LEVEL)      stall_cnt <= '0;
                else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        nxt_st    = cur_st;
        level_n   = level_q;
        dir_n     = dir_q;
        mode_n    = mode_q;
        dwell_n   = dwell_cnt;
        set_stall = 1'b0;
        reversing = (tgt_mag != 9'd0) && (tgt_dir != dir_q);
        if (cur_st == ST_FAULT) begin
            level_n = '0;
            mode_n  = DRIVE_OFF;
            if (clear_fault && !motor_fault) nxt_st = ST_IDLE;
        end else if (motor_fault || stall_hit) begin
            nxt_st    = ST_FAULT;
            level_n   = '0;
            mode_n    = DRIVE_OFF;
            set_stall = stall_hit;
        end else if (tgt_brake) begin
            nxt_st  = ST_BRAKE;
            level_n = tgt_mag;
            mode_n  = DRIVE_FAST_BRAKE;
        end else begin
            case (cur_st)
                ST_IDLE: begin
                    level_n = '0;
                    mode_n  = DRIVE_OFF;
                    if (tgt_mag != 9'd0) begin
                        nxt_st  = ST_RUN;
                        dir_n   = tgt_dir;
                        level_n = toward_tgt;
                        mode_n  = DRIVE_SLOW;
                    end
                end
                ST_RUN: begin
                    mode_n = DRIVE_SLOW;
                    if (reversing && level_q != 9'd0) begin
                        nxt_st  = ST_RAMP_DOWN;
                        level_n = toward_zero;
                    end else if (reversing) begin
                        nxt_st  = ST_DWELL;
                        level_n = '0;
                        mode_n  = DRIVE_OFF;
                        dwell_n = '0;
                    end else begin
                        level_n = toward_tgt;
                        if (toward_tgt == 9'd0 && tgt_mag == 9'd0) begin
                            nxt_st = ST_IDLE;
                            mode_n = DRIVE_OFF;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    mode_n = DRIVE_SLOW;
                    if (!reversing) begin
                        nxt_st  = ST_RUN;
                        level_n = toward_tgt;
                    end else if (toward_zero == 9'd0) begin
                        nxt_st  = ST_DWELL;
                        level_n = '0;
                        mode_n  = DRIVE_OFF;
                        dwell_n = '0;
                    end else begin
                        level_n = toward_zero;
                    end
                end
                ST_DWELL: begin
                    level_n = '0;
                    mode_n  = DRIVE_OFF;
                    if (tgt_mag == 9'd0) begin
                        nxt_st = ST_IDLE;
                    end else if (!reversing || dwell_cnt == DWELL_LAST) begin
                        nxt_st  = ST_RUN;
                        dir_n   = tgt_dir;
                        level_n = toward_tgt;
                        mode_n  = DRIVE_SLOW;
                    end else begin
                        dwell_n = dwell_cnt + DW'(1);
                    end
                end
                ST_BRAKE: begin
                    nxt_st  = ST_IDLE;
                    level_n = '0;
                    mode_n  = DRIVE_OFF;
                end
                default: begin
                    nxt_st  = ST_IDLE;
                    level_n = '0;
                    mode_n  = DRIVE_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st    <= ST_IDLE;
            level_q   <= '0;
            dir_q     <= 1'b0;
            mode_q    <= DRIVE_OFF;
            dwell_cnt <= '0;
            stall_q   <= 1'b0;
        end else if (tick) begin
            cur_st    <= nxt_st;
            level_q   <= level_n;
            dir_q     <= dir_n;
            mode_q    <= mode_n;
            dwell_cnt <= dwell_n;
            if (set_stall)       stall_q <= 1'b1;
            else if (fault_exit) stall_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb/tb_motor_cmd_sequencer.sv - self-checking bench for motor_cmd_sequencer
module tb_motor_cmd_sequencer;
    import motor_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] pwm_phase = 9'h1f8;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_duty = '0;
    logic       cmd_brake = 1'b0;
    logic [2:0] hall = '0;
    logic       motor_fault = 1'b0;
    logic       new_direction;
    logic [8:0] new_level;
    logic [1:0] drive_mode;
    logic       clear_fault = 1'b0;
    logic       stall;
    logic       fault_latched;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;
    logic [14:0] sb_q[$];

    motor_cmd_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pwm_phase     (pwm_phase),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_duty      (cmd_duty),
        .cmd_brake     (cmd_brake),
        .hall          (hall),
        .motor_fault   (motor_fault),
        .new_direction (new_direction),
        .new_level     (new_level),
        .drive_mode    (drive_mode),
        .clear_fault   (clear_fault),
        .stall         (stall),
        .fault_latched (fault_latched),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Compressed PWM period of 8 clocks covering the phases around the update point.
    always @(posedge clk) begin
        #2;
        pwm_phase = (pwm_phase == 9'h1ff) ? 9'h1f8 : pwm_phase + 9'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_tick();
        do @(negedge clk); while (pwm_phase != 9'h1fe);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cmd_brake = 1'b0; cmd_duty = '0;
        motor_fault = 1'b0; clear_fault = 1'b0; hall = '0;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic drive_cmd(input logic [9:0] duty, input logic brake);
        cmd_valid = 1'b1; cmd_duty = duty; cmd_brake = brake;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [1:0] md, input logic dir, input int lvl);
        sb_q.push_back({st, md, dir, 9'(lvl)});
    endtask

    task automatic push_slew(input int from, input int to, input logic [2:0] st, input logic dir);
        int l;
        l = from;
        while (l != to) begin
            if (to > l) l = (to - l > 8) ? l + 8 : to;
            else        l = (l - to > 8) ? l - 8 : to;
            push_exp(st, 2'b01, dir, l);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0; #1;
        vectors++;
        if ({state, drive_mode, new_direction, new_level, stall, fault_latched} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {state, drive_mode, new_direction, new_level, stall, fault_latched});
        end
        repeat (2) @(negedge clk); rst_n = 1'b1; @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        next_tick();
        vectors++;
        if (state !== ST_IDLE || new_level !== 9'd0) begin
            miscompares++; $display("FAIL reset_idle: state %0d level %0d want 0/0", state, new_level);
        end
    endtask

    task automatic test_ramp_up();
        logic [14:0] exp_v, obs_v;
        do_reset(); next_tick();
        push_slew(0, 100, ST_RUN, 1'b0);
        push_exp(ST_RUN, 2'b01, 1'b0, 100);
        drive_cmd(10'd100, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL ramp_up: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_reverse();
        logic [14:0] exp_v, obs_v;
        push_slew(100, 4, ST_RAMP_DOWN, 1'b0);
        repeat (4) push_exp(ST_DWELL, 2'b00, 1'b0, 0);
        push_slew(0, 40, ST_RUN, 1'b1);
        drive_cmd(10'h3d8, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL reverse: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_brake();
        logic [14:0] exp_v, obs_v;
        do_reset(); next_tick();
        push_slew(0, 200, ST_RUN, 1'b0);
        drive_cmd(10'd200, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL brake_ramp: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
        push_exp(ST_BRAKE, 2'b10, 1'b0, 300);
        drive_cmd(10'd300, 1'b1);
        next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL brake_apply: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        push_exp(ST_IDLE, 2'b00, 1'b0, 0);
        push_exp(ST_IDLE, 2'b00, 1'b0, 0);
        drive_cmd(10'd0, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL brake_release: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_v, obs_v;
        do_reset(); next_tick();
        push_slew(0, 24, ST_RUN, 1'b0);
        push_exp(ST_RUN, 2'b01, 1'b0, 24);
        drive_cmd(10'd40, 1'b0);
        drive_cmd(10'd24, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL back_to_back: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_clamp();
        logic [14:0] exp_v, obs_v;
        do_reset(); next_tick();
        push_slew(0, 511, ST_RUN, 1'b1);
        drive_cmd(10'h200, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL clamp: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_stall();
        logic [14:0] exp_v, obs_v;
        do_reset(); next_tick();
        push_slew(0, 128, ST_RUN, 1'b0);
        drive_cmd(10'd128, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL stall_ramp: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
        hall = 3'b101;
        repeat (1023) next_tick();
        vectors++;
        if (stall !== 1'b0 || state !== ST_RUN || new_level !== 9'd128) begin
            miscompares++; $display("FAIL stall_early: stall %b state %0d level %0d want 0/1/128", stall, state, new_level);
        end
        next_tick();
        vectors++;
        if ({stall, fault_latched, cmd_ready, state, new_level} !== {1'b1, 1'b1, 1'b0, ST_FAULT, 9'd0}) begin
            miscompares++; $display("FAIL stall_fault: stall %b latched %b ready %b state %0d level %0d want 1/1/0/5/0",
                                    stall, fault_latched, cmd_ready, state, new_level);
        end
        clear_fault = 1'b1; next_tick(); clear_fault = 1'b0;
        vectors++;
        if ({stall, fault_latched, cmd_ready, state} !== {1'b0, 1'b0, 1'b1, ST_IDLE}) begin
            miscompares++; $display("FAIL stall_clear: stall %b latched %b ready %b state %0d want 0/0/1/0",
                                    stall, fault_latched, cmd_ready, state);
        end
        next_tick();
        vectors++;
        if (state !== ST_IDLE || new_level !== 9'd0) begin
            miscompares++; $display("FAIL stall_targets_cleared: state %0d level %0d want 0/0", state, new_level);
        end
    endtask

    task automatic test_motor_fault();
        logic [14:0] exp_v, obs_v;
        do_reset(); next_tick();
        push_slew(0, 50, ST_RUN, 1'b0);
        drive_cmd(10'd50, 1'b0);
        while (sb_q.size() > 0) begin
            next_tick(); exp_v = sb_q.pop_front(); obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL fault_ramp: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
        motor_fault = 1'b1; next_tick();
        vectors++;
        if ({state, drive_mode, new_level, fault_latched, stall, cmd_ready} !== {ST_FAULT, 2'b00, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL fault_enter: state %0d mode %0d level %0d latched %b stall %b ready %b want 5/0/0/1/0/0",
                                    state, drive_mode, new_level, fault_latched, stall, cmd_ready);
        end
        clear_fault = 1'b1; next_tick();
        vectors++;
        if (state !== ST_FAULT || fault_latched !== 1'b1) begin
            miscompares++; $display("FAIL fault_hold: state %0d latched %b want 5/1", state, fault_latched);
        end
        motor_fault = 1'b0; next_tick(); clear_fault = 1'b0;
        vectors++;
        if (state !== ST_IDLE || fault_latched !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL fault_clear: state %0d latched %b ready %b want 0/0/1", state, fault_latched, cmd_ready);
        end
    endtask

    task automatic test_capture_on_tick();
        logic [17:0] snap;
        logic [14:0] obs_v, exp_v;
        do_reset();
        do @(negedge clk); while (pwm_phase != 9'h1fd);
        cmd_valid = 1'b1; cmd_duty = 10'd16; cmd_brake = 1'b0;
        @(negedge clk); cmd_valid = 1'b0;
        vectors++;
        if (state !== ST_IDLE || new_level !== 9'd0) begin
            miscompares++; $display("FAIL tick_capture_early: state %0d level %0d want 0/0", state, new_level);
        end
        for (int p = 0; p < 2; p++) begin
            snap = {state, drive_mode, new_direction, new_level, stall, fault_latched, cmd_ready};
            repeat (7) begin
                @(negedge clk);
                vectors++;
                if ({state, drive_mode, new_direction, new_level, stall, fault_latched, cmd_ready} !== snap) begin
                    miscompares++; $display("FAIL output_hold: phase %h got %h want %h", pwm_phase,
                        {state, drive_mode, new_direction, new_level, stall, fault_latched, cmd_ready}, snap);
                end
            end
            @(negedge clk);
            exp_v = {ST_RUN, 2'b01, 1'b0, 9'(8 * (p + 1))};
            obs_v = {state, drive_mode, new_direction, new_level};
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL tick_capture_apply: st/md/dir/lvl got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset(); next_tick();
        drive_cmd(10'd200, 1'b0);
        repeat (3) next_tick();
        vectors++;
        if (new_level !== 9'd24) begin miscompares++; $display("FAIL mid_ramp_level: got %0d want 24", new_level); end
        #2 rst_n = 1'b0; #1;
        vectors++;
        if ({state, drive_mode, new_direction, new_level} !== 15'd0) begin
            miscompares++; $display("FAIL async_reset: got %h want 0", {state, drive_mode, new_direction, new_level});
        end
        @(negedge clk); rst_n = 1'b1;
        next_tick();
        vectors++;
        if (state !== ST_IDLE || new_level !== 9'd0) begin
            miscompares++; $display("FAIL reset_abandons: state %0d level %0d want 0/0", state, new_level);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_brake();
        test_back_to_back();
        test_clamp();
        test_stall();
        test_motor_fault();
        test_capture_on_tick();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
